grid_write_scheduler: RTL and testbench
=======================================

Name: grid_write_scheduler

Overview:
Sequences all writes into the 64x64 GridData tile RAM (4-bit colour index per cell) through its single write port. Two requesters share the port under fair round-robin arbitration. Requester A is the processor/game logic; requester B is the cursor/sprite engine. An internal clear engine sweeps every cell to a chosen colour. An optional frame gate holds all writes until vertical blank so the VGA read side never shows a half-updated frame.

Parameters:
ADDR_W, 12, grid address width (wraddress_gridData width)
DATA_W, 4, colour-index width (data_gridData width)
GRID_CELLS, 4096, cells swept by the clear engine (addresses 0..GRID_CELLS-1)

Ports:
iVGA_CLK  in  1  pixel clock; all logic on rising edge
iRST_n  in  1  asynchronous, active-low reset
a_req  in  1  requester A write request, level
a_addr  in  ADDR_W  A cell address, stable while a_req=1 and until a_ack
a_data  in  DATA_W  A colour index
a_ack  out  1  one-cycle pulse: A's write issued this cycle
b_req / b_addr / b_data / b_ack  same as A, for requester B
clr_start  in  1  pulse: start a full-grid clear
clr_color  in  DATA_W  fill colour, sampled on clr_start
clr_busy  out  1  high while the clear sweep runs
clr_done  out  1  one-cycle pulse after the last clear write
gate_en  in  1  1 = writes only allowed during vblank
vblank  in  1  1 = display in vertical blanking
wren_gridData  out  1  GridData write enable
wraddress_gridData  out  ADDR_W  GridData write address
data_gridData  out  DATA_W  GridData write data

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer = A, clear counter 0. Reset mid-clear aborts the sweep. clr_done is not pulsed.
- All outputs are registered. At most one write is issued per cycle.
- open = ~gate_en | vblank. While open=0, no write is issued; pending requests and the clear counter hold.
- IDLE/arbitration, at each edge with open=1:
  - eligible_A = a_req & ~a_ack; same rule for B. A requester is never granted in the cycle its ack is high, so its stale address is not re-written.
  - One eligible requester: grant it.
  - Both eligible: grant the one not granted last, then update the pointer.
  - Grant: next cycle wren=1, addr/data = granted requester's values, and its ack=1 in that same cycle.
  - Latency is req seen at edge n -> wren and ack high in cycle n+1.
  - One requester's maximum rate is 1 write per 2 cycles. A and B both requesting fill every cycle, alternating.
- No grant: wren=0. wraddress/data hold their last values.
- clr_start in IDLE:
  - Latch clr_color and enter CLEAR. clr_busy=1 from the next cycle.
  - clr_start takes priority over a request sampled at the same edge; that request stays pending.
- CLEAR state:
  - Each open cycle writes clr_color to the counter address, counter 0..GRID_CELLS-1 incrementing by 1.
  - A and B are not acked; their requests remain pending.
  - clr_start during CLEAR is ignored.
- CLEAR exit:
  - After the write to GRID_CELLS-1, the next cycle has clr_busy=0 and clr_done=1 for one cycle.
  - Return to IDLE. Pending requests are arbitrated from the edge ending the clr_done cycle, so the first ack appears the cycle after clr_done.
- A clear with gate_en=0 takes exactly GRID_CELLS write cycles, 4096 by default.
- The counter is ADDR_W+1 bits wide internally, so GRID_CELLS = 2^ADDR_W does not wrap before termination.
- Requester protocol: hold req/addr/data until ack is seen. Then either drop req or present new addr/data with req kept high.

Test Plan:
1. Reset, then drive a_req=1, a_addr=0x123, a_data=5 at edge n -> cycle n+1: wren=1, wraddress=0x123, data=5, a_ack=1. Drop a_req on the ack -> wren=0 afterwards. Assert iRST_n=0 mid-sequence -> all outputs 0 immediately.
2. A and B request continuously with fixed addresses 0x010/0x020 -> wren high every cycle, alternating A,B,A,B. Each ack is 1 cycle, never the same requester twice in a row.
3. A alone requesting continuously, new address on each ack -> writes every other cycle, no duplicate address.
4. clr_start with clr_color=3, gate_en=0, a_req held -> 4096 consecutive writes of 3 to addresses 0..4095, a_ack=0 throughout, clr_done pulse once. a_ack appears the cycle after clr_done.
5. gate_en=1 with vblank toggling 10 cycles on / 10 off during a clear -> writes occur only while vblank=1, addresses contiguous with no skips. Total writes = 4096.
6. clr_start pulsed again mid-clear, and iRST_n pulsed at address ~2000 -> the second start is ignored. Reset returns to IDLE with clr_busy=0 and no clr_done; a fresh clr_start restarts from address 0.

Source files
------------

// File: rtl/grid_write_scheduler.sv
// grid_write_scheduler
//   Sole writer of the 64x64 GridData tile RAM (one colour index per cell).
//   Two requesters share the write port under round-robin arbitration. A
//   built-in clear engine sweeps every cell to one colour. An optional frame
//   gate holds every write until vertical blank.
// Ports
//   iVGA_CLK, iRST_n              clock, asynchronous active-low reset
//   a_req/a_addr/a_data -> a_ack  requester A (processor / game logic)
//   b_req/b_addr/b_data -> b_ack  requester B (cursor / sprite engine)
//   clr_start, clr_color          start a full-grid clear with this colour
//   clr_busy, clr_done            sweep running / one-cycle completion pulse
//   gate_en, vblank               write gate: writes only while vblank if enabled
//   wren/wraddress/data_gridData  registered RAM write port
module grid_write_scheduler #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 4,
  parameter int GRID_CELLS = 4096
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ack,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ack,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              gate_en,
  input  logic              vblank,
  output logic              wren_gridData,
  output logic [ADDR_W-1:0] wraddress_gridData,
  output logic [DATA_W-1:0] data_gridData
);

  // One extra bit so GRID_CELLS == 2**ADDR_W is reachable as the end marker.
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic              rr_b_q, rr_b_d;     // 1: B wins the next tie
  logic              wren_q, wren_d;
  wr_t               wr_q, wr_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic open, elig_a, elig_b, grant_a, grant_b;

  assign open    = ~gate_en | vblank;
  // A requester whose ack is showing still presents the address just written.
  assign elig_a  = a_req & ~a_ack_q;
  assign elig_b  = b_req & ~b_ack_q;
  assign grant_a = elig_a & (~elig_b | ~rr_b_q);
  assign grant_b = elig_b & ~grant_a;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    rr_b_d  = rr_b_q;
    wren_d  = 1'b0;
    wr_d    = wr_q;
    a_ack_d = 1'b0;
    b_ack_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          // Clear wins over a same-edge request; the request simply waits.
          state_d = ST_CLEAR;
          cnt_d   = '0;
          color_d = clr_color;
          busy_d  = 1'b1;
        end else if (open) begin
          if (grant_a) begin
            wren_d  = 1'b1;
            wr_d    = '{addr: a_addr, data: a_data};
            a_ack_d = 1'b1;
            rr_b_d  = 1'b1;
          end else if (grant_b) begin
            wren_d  = 1'b1;
            wr_d    = '{addr: b_addr, data: b_data};
            b_ack_d = 1'b1;
            rr_b_d  = 1'b0;
          end
        end
      end
      ST_CLEAR: begin
        if (cnt_q == CNT_W'(GRID_CELLS)) begin
          // Last clear write is on the port now; report done and hand back.
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (open) begin
          wren_d = 1'b1;
          wr_d   = '{addr: cnt_q[ADDR_W-1:0], data: color_q};
          cnt_d  = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      color_q <= '0;
      rr_b_q  <= 1'b0;
      wren_q  <= 1'b0;
      wr_q    <= '0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
      rr_b_q  <= rr_b_d;
      wren_q  <= wren_d;
      wr_q    <= wr_d;
      a_ack_q <= a_ack_d;
      b_ack_q <= b_ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign a_ack              = a_ack_q;
  assign b_ack              = b_ack_q;
  assign clr_busy           = busy_q;
  assign clr_done           = done_q;
  assign wren_gridData      = wren_q;
  assign wraddress_gridData = wr_q.addr;
  assign data_gridData      = wr_q.data;

endmodule

// File: tb/tb_grid_write_scheduler.sv
// tb_grid_write_scheduler
//   Directed bench for grid_write_scheduler. A cycle-level behavioural model
//   predicts every output each cycle; directed sequences add literal checks.
module tb_grid_write_scheduler;
  localparam int AW    = 12;
  localparam int DW    = 4;
  localparam int CELLS = 4096;

  logic          iVGA_CLK = 1'b0;
  logic          iRST_n   = 1'b0;
  logic          a_req = 0, b_req = 0, clr_start = 0, gate_en = 0, vblank = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0, clr_color = '0;
  logic          a_ack, b_ack, clr_busy, clr_done, wren_gridData;
  logic [AW-1:0] wraddress_gridData;
  logic [DW-1:0] data_gridData;

  grid_write_scheduler #(.ADDR_W(AW), .DATA_W(DW), .GRID_CELLS(CELLS)) dut (
    .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
    .clr_start(clr_start), .clr_color(clr_color),
    .clr_busy(clr_busy), .clr_done(clr_done),
    .gate_en(gate_en), .vblank(vblank),
    .wren_gridData(wren_gridData), .wraddress_gridData(wraddress_gridData),
    .data_gridData(data_gridData)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 0;

  // ---------------- behavioural model ----------------
  bit          m_clearing;
  int          m_next_cell;
  bit          m_b_next;      // B gets the next tie
  logic [DW-1:0] m_color;
  logic          e_wren, e_aack, e_back, e_busy, e_done;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  task automatic m_reset();
    m_clearing = 0; m_next_cell = 0; m_b_next = 0; m_color = '0;
    e_wren = 0; e_aack = 0; e_back = 0; e_busy = 0; e_done = 0;
    e_addr = '0; e_data = '0;
  endtask

  task automatic m_step();
    bit open, wa, wb, pick_b;
    open = !gate_en || vblank;
    wa = a_req && !e_aack;
    wb = b_req && !e_back;
    e_wren = 0; e_aack = 0; e_back = 0; e_done = 0;
    if (!m_clearing) begin
      if (clr_start) begin
        m_clearing = 1; m_next_cell = 0; m_color = clr_color; e_busy = 1;
      end else if (open && (wa || wb)) begin
        pick_b = (wa && wb) ? m_b_next : wb;
        m_b_next = !pick_b;
        e_wren = 1;
        if (pick_b) begin e_addr = b_addr; e_data = b_data; e_back = 1; end
        else        begin e_addr = a_addr; e_data = a_data; e_aack = 1; end
      end
    end else if (m_next_cell == CELLS) begin
      m_clearing = 0; e_busy = 0; e_done = 1;
    end else if (open) begin
      e_wren = 1; e_addr = AW'(m_next_cell); e_data = m_color;
      m_next_cell = m_next_cell + 1;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge iVGA_CLK or negedge iRST_n);
      if (!iRST_n) m_reset();
      else m_step();
    end
  end

  // One compare per cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge iVGA_CLK);
      if (cmp_en) begin
        n_vec++;
        if ({wren_gridData, wraddress_gridData, data_gridData, a_ack, b_ack, clr_busy, clr_done} !==
            {e_wren, e_addr, e_data, e_aack, e_back, e_busy, e_done}) begin
          n_err++;
          $display("FAIL model_cmp t=%0t got wren=%b addr=%h data=%h ack=%b%b busy=%b done=%b exp wren=%b addr=%h data=%h ack=%b%b busy=%b done=%b",
                   $time, wren_gridData, wraddress_gridData, data_gridData, a_ack, b_ack, clr_busy, clr_done,
                   e_wren, e_addr, e_data, e_aack, e_back, e_busy, e_done);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge iVGA_CLK);
    #1;
  endtask

  int nw, bad, nd, who, prev, ea, done_at, vg;
  logic pv;

  initial begin
    // ---- T1: reset, single write, async reset ----
    repeat (3) tick();
    cmp_en = 1;
    chk("rst_wren", wren_gridData, 0);
    chk("rst_addr", wraddress_gridData, 0);
    chk("rst_busy", clr_busy, 0);
    iRST_n = 1;
    tick();
    a_req = 1; a_addr = 12'h123; a_data = 4'd5;
    tick();
    chk("t1_wren", wren_gridData, 1);
    chk("t1_addr", wraddress_gridData, 'h123);
    chk("t1_data", data_gridData, 5);
    chk("t1_ack", a_ack, 1);
    a_req = 0;
    tick();
    chk("t1_wren_after", wren_gridData, 0);
    chk("t1_addr_hold", wraddress_gridData, 'h123);
    a_req = 1; a_addr = 12'h2AB; a_data = 4'd9;
    tick();
    chk("t1_second_wren", wren_gridData, 1);
    #3 iRST_n = 0;
    #1;
    chk("t1_async_wren", wren_gridData, 0);
    chk("t1_async_addr", wraddress_gridData, 0);
    chk("t1_async_ack", a_ack, 0);
    a_req = 0;
    tick();
    iRST_n = 1;
    tick();

    // ---- T2: both requesting, fixed addresses ----
    a_req = 1; a_addr = 12'h010; a_data = 4'd1;
    b_req = 1; b_addr = 12'h020; b_data = 4'd2;
    nw = 0; bad = 0; prev = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wren_gridData) begin
        nw++;
        who = a_ack ? 0 : 1;
        if (a_ack == b_ack) bad++;
        if (who == prev) bad++;
        if (int'(wraddress_gridData) != (who == 1 ? 'h20 : 'h10)) bad++;
        prev = who;
      end
    end
    chk("t2_writes", nw, 20);
    chk("t2_alternation_errs", bad, 0);
    a_req = 0; b_req = 0;
    repeat (2) tick();

    // ---- T3: A alone, new address on each ack ----
    a_req = 1; a_addr = 12'h100; a_data = 4'd7;
    nw = 0; bad = 0; ea = 'h100;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (a_ack) begin
        if (!wren_gridData || int'(wraddress_gridData) != ea || data_gridData != 4'd7) bad++;
        ea++; nw++;
        a_addr = a_addr + 1'b1;
      end
    end
    chk("t3_writes", nw, 10);
    chk("t3_addr_errs", bad, 0);
    a_req = 0;
    repeat (2) tick();

    // ---- T4: full clear with A pending ----
    a_req = 1; a_addr = 12'h3FF; a_data = 4'd1;
    clr_color = 4'd3; clr_start = 1;
    tick();
    clr_start = 0; clr_color = 4'd0;
    chk("t4_busy", clr_busy, 1);
    chk("t4_no_ack_at_start", a_ack, 0);
    nw = 0; bad = 0; nd = 0; done_at = -1;
    for (int i = 0; i < 5000 && nd == 0; i++) begin
      tick();
      if (a_ack) bad++;
      if (wren_gridData) begin
        if (wraddress_gridData != nw[AW-1:0] || data_gridData != 4'd3) bad++;
        nw++;
      end
      if (clr_done) begin nd++; done_at = i; end
    end
    chk("t4_writes", nw, 4096);
    chk("t4_errs", bad, 0);
    chk("t4_done_cycle", done_at, 4096);
    tick();
    chk("t4_done_single", clr_done, 0);
    chk("t4_ack_after_done", a_ack, 1);
    chk("t4_ack_addr", wraddress_gridData, 'h3FF);
    a_req = 0;
    tick();

    // ---- T5: gated clear, vblank 10 on / 10 off ----
    gate_en = 1; vblank = 0;
    clr_color = 4'hA; clr_start = 1;
    tick();
    clr_start = 0;
    nw = 0; bad = 0; nd = 0; vg = 0;
    for (int i = 0; i < 20000 && nd == 0; i++) begin
      pv = vblank;
      tick();
      if (wren_gridData) begin
        if (!pv) vg++;
        if (wraddress_gridData != nw[AW-1:0] || data_gridData != 4'hA) bad++;
        nw++;
      end
      if (clr_done) nd++;
      if (i % 10 == 9) vblank = ~vblank;
    end
    chk("t5_writes", nw, 4096);
    chk("t5_addr_errs", bad, 0);
    chk("t5_writes_outside_vblank", vg, 0);
    chk("t5_done", nd, 1);
    gate_en = 0; vblank = 0;
    tick();

    // ---- T6: restart ignored, reset mid-clear, fresh start ----
    clr_color = 4'd5; clr_start = 1;
    tick();
    clr_start = 0;
    for (int i = 0; i < 500 && !(wren_gridData && wraddress_gridData == 12'd100); i++) tick();
    clr_color = 4'd9; clr_start = 1;
    tick();
    clr_start = 0;
    chk("t6_still_busy", clr_busy, 1);
    chk("t6_addr_continues", wraddress_gridData, 101);
    chk("t6_color_kept", data_gridData, 5);
    for (int i = 0; i < 3000 && !(wren_gridData && wraddress_gridData == 12'd2000); i++) tick();
    chk("t6_reach_2000", wraddress_gridData, 2000);
    #3 iRST_n = 0;
    #1;
    chk("t6_rst_busy", clr_busy, 0);
    chk("t6_rst_wren", wren_gridData, 0);
    tick();
    iRST_n = 1;
    nd = 0;
    repeat (10) begin
      tick();
      if (clr_done || clr_busy || wren_gridData) nd++;
    end
    chk("t6_quiet_after_rst", nd, 0);
    clr_color = 4'd6; clr_start = 1;
    tick();
    clr_start = 0;
    tick();
    chk("t6_fresh_wren", wren_gridData, 1);
    chk("t6_fresh_addr", wraddress_gridData, 0);
    chk("t6_fresh_data", data_gridData, 6);
    nd = 0;
    for (int i = 0; i < 5000 && nd == 0; i++) begin
      tick();
      if (clr_done) nd++;
    end
    chk("t6_fresh_done", nd, 1);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
